seg7_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a multi-digit common-select 7-segment display. It holds a DIGITS-wide BCD value and cycles through the digit positions, one at a time. For each position it drives the shared BCD-to-segment decoder and a one-hot digit select, with inter-digit blanking and optional leading-zero suppression. It sits between the value producers (counters, priority encoder outputs) and the board display pins.

---
 rtl/seg7_pkg.sv | 29 ++
 rtl/seg7.sv | 25 ++
 rtl/seg7_scan_ctrl.sv | 145 ++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed 7-segment display blocks:
// segment codes, scan states and the index-width helper.
package seg7_pkg;

    // Segment order is {a,b,c,d,e,f,g}, active-high.
    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110010;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    // Width needed to count 0..n-1; a 1-bit field is kept even when n is 1.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg7.sv
// Combinational BCD-to-7-segment decoder; non-decimal codes render dark.
module seg7
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a DIGITS-wide 7-segment display with
// per-slot blanking, leading-zero suppression and frame-aligned value updates.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value_in,
    input  logic                  lz_en,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_start,
    output logic                  pending
);

    localparam int IW = idx_width(DIGITS);
    localparam int CW = idx_width(PRESCALE);

    state_t              state;
    state_t              nxt_state;
    logic [IW-1:0]       idx;
    logic [IW-1:0]       nxt_idx;
    logic [CW-1:0]       cnt;
    logic [CW-1:0]       nxt_cnt;
    logic                boundary;
    logic [4*DIGITS-1:0] shadow;
    logic [4*DIGITS-1:0] active;

    logic [3:0]          nib;
    logic                suppress;
    logic                zero_run;
    logic [6:0]          dec_seg;
    logic [6:0]          nxt_seg;
    logic [DIGITS-1:0]   nxt_an;

    // Next-state logic. Outputs are registered from the next-state values so
    // that state, seg, an and frame_start all move on the same edge.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
        nxt_state = state;
        nxt_idx   = idx;
        nxt_cnt   = cnt;
        boundary  = 1'b0;
        if (!enable) begin
            nxt_state = IDLE;
            nxt_idx   = '0;
            nxt_cnt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    nxt_state = BLANK;
                    nxt_idx   = '0;
                    nxt_cnt   = '0;
                    boundary  = 1'b1;
                end
                BLANK: begin
                    nxt_cnt = cnt + CW'(1);
                    if (cnt == CW'(BLANK_CYCLES - 1)) nxt_state = SHOW;
                end
                SHOW: begin
                    if (cnt == CW'(PRESCALE - 1)) begin
                        nxt_state = BLANK;
                        nxt_cnt   = '0;
                        nxt_idx   = (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
                        boundary  = (nxt_idx == '0);
                    end else begin
                        nxt_cnt = cnt + CW'(1);
                    end
                end
                default: begin
                    nxt_state = IDLE;
                    nxt_idx   = '0;
                    nxt_cnt   = '0;
                end
            endcase
        end
    end

    // Pick the nibble for the upcoming digit; zero_run tracks whether every
    // nibble from the top down to the current position is zero.
    always_comb begin
        nib      = '0;
        suppress = 1'b0;
        zero_run = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (active[4*i +: 4] == 4'd0);
            if (nxt_idx == IW'(i)) begin
                nib      = active[4*i +: 4];
                suppress = lz_en && zero_run && (i != 0);
            end
        end
    end

    seg7 u_dec (
        .bcd (nib),
        .seg (dec_seg)
    );

    always_comb begin
        nxt_seg = SEG_BLANK;
        nxt_an  = '0;
        if (nxt_state == SHOW) begin
            nxt_an  = DIGITS'(1) << nxt_idx;
            nxt_seg = suppress ? SEG_BLANK : dec_seg;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            cnt         <= '0;
            shadow      <= '0;
            active      <= '0;
            pending     <= 1'b0;
            seg         <= SEG_BLANK;
            an          <= '0;
            frame_start <= 1'b0;
        end else begin
            state       <= nxt_state;
            idx         <= nxt_idx;
            cnt         <= nxt_cnt;
            seg         <= nxt_seg;
            an          <= nxt_an;
            frame_start <= boundary;

            // Commit uses the pre-edge shadow, so a coincident load stays pending.
            if (boundary && pending) active <= shadow;
            if (load) begin
                shadow  <= value_in;
                pending <= 1'b1;
            end else if (boundary) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: directed frame sequences, a vector
// table and a randomized run against a time-based reference model.
module tb_seg7_scan_ctrl;

    localparam int DIGITS       = 4;
    localparam int PRESCALE     = 8;
    localparam int BLANK_CYCLES = 2;
    localparam int FRAME        = DIGITS * PRESCALE;
    localparam int HIST         = 8192;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        load;
    logic [15:0] value_in;
    logic        lz_en;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_start;
    logic        pending;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(
        .DIGITS       (DIGITS),
        .PRESCALE     (PRESCALE),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .load        (load),
        .value_in    (value_in),
        .lz_en       (lz_en),
        .seg         (seg),
        .an          (an),
        .frame_start (frame_start),
        .pending     (pending)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input int n);
        case (n)
            0: return 7'b1111110;
            1: return 7'b0110000;
            2: return 7'b1101101;
            3: return 7'b1111001;
            4: return 7'b0110011;
            5: return 7'b1011011;
            6: return 7'b1011111;
            7: return 7'b1110010;
            8: return 7'b1111111;
            9: return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    // Reference model: a frame is a linear timeline of FRAME cycles; digit and
    // slot phase come from division, not from a state machine.
    bit          m_valid = 1'b0;
    bit          m_run;
    int          m_t;
    logic [15:0] m_shadow;
    logic [15:0] m_active;
    bit          m_pending;
    logic [6:0]  e_seg;
    logic [3:0]  e_an;
    bit          e_fs;

    int          cyc = 0;
    logic [6:0]  h_seg  [HIST];
    logic [3:0]  h_an   [HIST];
    logic        h_fs   [HIST];
    logic        h_pend [HIST];

    task automatic step();
        logic [15:0] v;
        logic [15:0] upper;
        bit l, e, r, z, bnd;
        int d;
        v = value_in; l = load; e = enable; r = rst; z = lz_en;
        @(posedge clk);
        if (r) begin
            m_valid = 1'b1; m_run = 1'b0; m_t = 0;
            m_shadow = '0; m_active = '0; m_pending = 1'b0;
            e_seg = '0; e_an = '0; e_fs = 1'b0;
        end else begin
            bnd = 1'b0;
            if (!e) begin
                m_run = 1'b0; m_t = 0;
            end else if (!m_run) begin
                m_run = 1'b1; m_t = 0; bnd = 1'b1;
            end else begin
                m_t = (m_t + 1) % FRAME;
                bnd = (m_t == 0);
            end
            if (bnd && m_pending) begin
                m_active  = m_shadow;
                m_pending = 1'b0;
            end
            if (l) begin
                m_shadow  = v;
                m_pending = 1'b1;
            end
            e_fs = bnd; e_seg = '0; e_an = '0;
            if (m_run && (m_t % PRESCALE) >= BLANK_CYCLES) begin
                d     = m_t / PRESCALE;
                e_an  = 4'(1 << d);
                upper = m_active >> (4 * d);
                if (!(z && d > 0 && upper == 16'd0)) e_seg = seg_of(int'(upper & 16'hF));
            end
        end
        #1;
        cyc++;
        h_seg[cyc] = seg; h_an[cyc] = an; h_fs[cyc] = frame_start; h_pend[cyc] = pending;
        if (m_valid) begin
            check($sformatf("model_seg c%0d", cyc), 32'(seg), 32'(e_seg));
            check($sformatf("model_an c%0d", cyc), 32'(an), 32'(e_an));
            check($sformatf("model_fs c%0d", cyc), 32'(frame_start), 32'(e_fs));
            check($sformatf("model_pend c%0d", cyc), 32'(pending), 32'(m_pending));
        end
    endtask

    typedef struct {
        logic [15:0]      value;
        logic             lz;
        logic [3:0][6:0]  exp_seg;
    } vec_t;

    vec_t vecs[6];
    int   t0;

    initial begin
        vecs[0] = '{16'h1234, 1'b0, {7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011}};
        vecs[1] = '{16'h0050, 1'b1, {7'b0000000, 7'b0000000, 7'b1011011, 7'b1111110}};
        vecs[2] = '{16'h0000, 1'b1, {7'b0000000, 7'b0000000, 7'b0000000, 7'b1111110}};
        vecs[3] = '{16'h00A0, 1'b0, {7'b1111110, 7'b1111110, 7'b0000000, 7'b1111110}};
        vecs[4] = '{16'h9876, 1'b0, {7'b1111011, 7'b1111111, 7'b1110010, 7'b1011111}};
        vecs[5] = '{16'h0500, 1'b1, {7'b0000000, 7'b1011011, 7'b1111110, 7'b1111110}};

        rst = 1'b1; enable = 1'b0; load = 1'b0; value_in = '0; lz_en = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
        check("reset_seg", 32'(seg), 32'd0);
        check("reset_an", 32'(an), 32'd0);
        check("reset_fs", 32'(frame_start), 32'd0);
        check("reset_pend", 32'(pending), 32'd0);

        // Load while idle, then start scanning.
        load = 1'b1; value_in = 16'h1234;
        step();
        load = 1'b0;
        check("pend_after_load", 32'(pending), 32'd1);
        step();
        enable = 1'b1;
        step();
        t0 = cyc - 1;
        repeat (40) step();
        check("first_pend_drop", 32'(h_pend[t0+1]), 32'd0);
        check("first_fs", 32'(h_fs[t0+1]), 32'd1);
        foreach (vecs[0].exp_seg[k]) begin end
        for (int k = 3; k <= 8; k++) begin
            check($sformatf("d0_an k%0d", k), 32'(h_an[t0+k]), 32'h1);
            check($sformatf("d0_seg k%0d", k), 32'(h_seg[t0+k]), 32'h33);
        end
        for (int k = 11; k <= 16; k++) begin
            check($sformatf("d1_an k%0d", k), 32'(h_an[t0+k]), 32'h2);
            check($sformatf("d1_seg k%0d", k), 32'(h_seg[t0+k]), 32'h79);
        end
        for (int j = 0; j < 4; j++) begin
            int k;
            k = (j < 2) ? j + 1 : j + 7;
            check($sformatf("blank_an k%0d", k), 32'(h_an[t0+k]), 32'd0);
            check($sformatf("blank_seg k%0d", k), 32'(h_seg[t0+k]), 32'd0);
        end
        check("fs_gap", 32'(h_fs[t0+32]), 32'd0);
        check("second_fs", 32'(h_fs[t0+33]), 32'd1);

        // Mid-frame loads during digit 2, then a load on the boundary edge.
        enable = 1'b0;
        step();
        enable = 1'b1;
        for (int k = 1; k <= 110; k++) begin
            load = (k == 20) || (k == 21) || (k == 33);
            value_in = (k == 20) ? 16'h1111 : (k == 21) ? 16'h2222 : 16'h3333;
            step();
            if (k == 1) t0 = cyc - 1;
        end
        load = 1'b0;
        check("old_d3_an", 32'(h_an[t0+30]), 32'h8);
        check("old_d3_seg", 32'(h_seg[t0+30]), 32'h30);
        for (int d = 0; d < 4; d++) begin
            check($sformatf("new_an d%0d", d), 32'(h_an[t0+37+8*d]), 32'(1 << d));
            check($sformatf("new_seg d%0d", d), 32'(h_seg[t0+37+8*d]), 32'h6D);
        end
        check("bnd_load_pend", 32'(h_pend[t0+34]), 32'd1);
        check("bnd_load_commit", 32'(h_pend[t0+66]), 32'd0);
        check("bnd_load_frame1", 32'(h_seg[t0+61]), 32'h6D);
        check("bnd_load_frame2", 32'(h_seg[t0+69]), 32'h79);

        // Drop enable mid-SHOW, restart, then reset mid-SHOW with a load pending.
        check("pre_drop_an", 32'(an), 32'h2);
        enable = 1'b0;
        step();
        check("drop_an", 32'(an), 32'd0);
        check("drop_seg", 32'(seg), 32'd0);
        enable = 1'b1;
        step();
        t0 = cyc - 1;
        check("restart_fs", 32'(frame_start), 32'd1);
        step(); step();
        check("restart_an", 32'(an), 32'h1);
        check("restart_seg", 32'(seg), 32'h79);
        load = 1'b1; value_in = 16'h5555;
        step();
        load = 1'b0;
        check("pre_rst_pend", 32'(pending), 32'd1);
        rst = 1'b1;
        step();
        check("rst_seg", 32'(seg), 32'd0);
        check("rst_an", 32'(an), 32'd0);
        check("rst_pend", 32'(pending), 32'd0);
        check("rst_fs", 32'(frame_start), 32'd0);
        rst = 1'b0;

        // Table vectors: one full frame each, sampled mid-SHOW per digit.
        foreach (vecs[i]) begin
            enable = 1'b0; load = 1'b1; value_in = vecs[i].value; lz_en = vecs[i].lz;
            step();
            load = 1'b0;
            step();
            enable = 1'b1;
            step();
            t0 = cyc - 1;
            repeat (32) step();
            for (int d = 0; d < 4; d++) begin
                check($sformatf("vec%0d_an d%0d", i, d), 32'(h_an[t0+5+8*d]), 32'(1 << d));
                check($sformatf("vec%0d_seg d%0d", i, d), 32'(h_seg[t0+5+8*d]), 32'(vecs[i].exp_seg[d]));
            end
        end

        // Randomized run, checked every cycle against the model inside step().
        for (int n = 0; n < 3000; n++) begin
            enable = ($urandom_range(0, 99) != 0);
            load   = ($urandom_range(0, 19) == 0);
            rst    = ($urandom_range(0, 499) == 0);
            for (int b = 0; b < 4; b++)
                value_in[4*b +: 4] = $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0) lz_en = ~lz_en;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
